// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, D = A - B, LSB first
//
// One full-subtractor cell plus shift registers. An operation accepted on a
// start edge takes WIDTH edges and then raises done for one cycle.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; clears state and results
//   start  request; accepted only in IDLE or DONE
//   A, B   minuend / subtrahend, captured on the accepted start edge
//   busy   high while bits are being processed
//   done   one-cycle pulse; D and Bout are valid
//   D      A - B modulo 2^WIDTH, held until the next completion
//   Bout   final borrow, 1 when A < B
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sr, b_sr, d_sr, d_next;
  logic             bw, bw_next, d_bit;
  logic [CW-1:0]    cnt;
  logic             accept, last_bit;

  // Full-subtractor cell on the current LSBs.
  always_comb begin
    d_bit   = a_sr[0] ^ b_sr[0] ^ bw;
    bw_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & bw);
    // Written as shift-then-insert so WIDTH=1 needs no zero-width slice.
    d_next           = d_sr >> 1;
    d_next[WIDTH-1]  = d_bit;
  end

  // DONE accepts start exactly like IDLE, giving gap-free back-to-back runs.
  assign accept   = start && ((state == S_IDLE) || (state == S_DONE));
  assign last_bit = (state == S_SHIFT) && (cnt == LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_SHIFT;
      S_SHIFT: if (cnt == LAST) state_next = S_DONE;
      S_DONE:  state_next = start ? S_SHIFT : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    busy = (state == S_SHIFT);
    done = (state == S_DONE);
  end

  // Datapath. start during SHIFT falls through to the shift branch untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr <= '0;
      b_sr <= '0;
      d_sr <= '0;
      bw   <= 1'b0;
      cnt  <= '0;
      D    <= '0;
      Bout <= 1'b0;
    end else if (accept) begin
      a_sr <= A;
      b_sr <= B;
      d_sr <= '0;
      bw   <= 1'b0;
      cnt  <= '0;
    end else if (state == S_SHIFT) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      d_sr <= d_next;
      bw   <= bw_next;
      cnt  <= cnt + CW'(1);
      // Results publish only on the completion edge and hold otherwise.
      if (last_bit) begin
        D    <= d_next;
        Bout <= bw_next;
      end
    end
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor computing D = A − B one bit per clock, LSB first, with a single borrow flip-flop. It is the subtract-direction counterpart to the team's gate-level adder blocks. It runs from a start/done handshake so a controller can issue operations back to back. The block trades latency for area: one full-subtractor cell plus shift registers replaces a WIDTH-bit ripple chain.

## Interface
- WIDTH, default 8, operand and result width in bits (legal range 1–32)
- clk  input  1  rising-edge clock, the only clock
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- start  input  1  request; sampled only when the block is idle or in DONE
- A  input  WIDTH  minuend, captured on the accepted start edge
- B  input  WIDTH  subtrahend, captured on the accepted start edge
- busy  output  1  high while bits are being processed
- done  output  1  single-cycle pulse, result valid
- D  output  WIDTH  difference A − B modulo 2^WIDTH, registered
- Bout  output  1  final borrow: 1 when A < B (unsigned)

## Operation
- States: IDLE, SHIFT, DONE. Internal regs: a_sr, b_sr, d_sr (WIDTH each), bw (borrow), cnt (ceil(log2(WIDTH+1)) bits).
- IDLE: start=1 → a_sr←A, b_sr←B, d_sr←0, bw←0, cnt←0, go SHIFT. start=0 → stay.
- SHIFT, each edge: a0=a_sr[0], b0=b_sr[0]; d=a0^b0^bw; bw←(~a0&b0)|(~(a0^b0)&bw); d_sr←{d, d_sr[WIDTH-1:1]}; a_sr, b_sr shift right (zero fill); cnt←cnt+1. On the edge where cnt==WIDTH−1 → go DONE and load D←final d_sr value and Bout←final bw in the same edge.
- DONE: lasts one cycle. start=1 → accepted exactly as in IDLE (go SHIFT). Else → IDLE.
- start while in SHIFT: ignored, with no effect on operands or count.
- A/B changes after the capture edge have no effect on the operation in flight.
- D and Bout change only on the completion edge. They hold through IDLE and the next operation until that operation completes.
- Outputs: busy=(state==SHIFT); done=(state==DONE).
- reset=1 at any edge, including mid-SHIFT: state←IDLE, D←0, Bout←0, busy=0, done=0, internal regs cleared. The in-flight operation is discarded with no done pulse. reset has priority over start.

## Timing
- Accepted start at edge E0. busy=1 from after E0 through edge E0+WIDTH.
- Bit k (0-based) is processed at edge E0+1+k.
- The completion edge is E0+WIDTH. After it, done=1, busy=0, and D/Bout are valid.
- done falls after E0+WIDTH+1.
- Latency from start edge to done is WIDTH cycles. Throughput is one result per WIDTH+1 cycles; back-to-back start during DONE gives one result per WIDTH+1 cycles with no idle gap.
- Reset values: busy=0, done=0, D=0, Bout=0.
- WIDTH=1 boundary: SHIFT lasts exactly one edge, and DONE follows immediately.

## Test plan
- WIDTH=8: reset 2 cycles, then start with A=200, B=55 → done exactly 8 cycles after start edge, D=145, Bout=0, busy high for 8 cycles.
- A=5, B=10 → D=251, Bout=1. Then A=0, B=0 → D=0, Bout=0. Then A=255, B=255 → D=0, Bout=0. Then A=0, B=1 → D=255, Bout=1.
- During a run with A=100, B=1: pulse start with A=7, B=9 at cycle 3 and change A/B every cycle → ignored; result D=99, Bout=0, exactly one done pulse.
- Assert start in the DONE cycle with A=17, B=18 → new run begins with no IDLE cycle. Prior result stays on D until the second done, then D=255, Bout=1.
- Assert reset at cycle 4 of a run → next edge busy=0, done=0, D=0, Bout=0. No done pulse ever appears for the aborted run. A fresh start afterwards completes normally.
- Instantiate with WIDTH=1 and run all four (A,B) pairs → each done 1 cycle after start. Results: (0,0)→D=0,Bout=0; (1,0)→1,0; (0,1)→1,1; (1,1)→0,0.
- Random compare against A−B reference model: 1000 operations → no mismatch.
